frame_swap_scheduler: RTL and testbench

- Sequences the double-buffered frame pipeline: ray marcher renders into the back buffer, VGA scans the front buffer.
- Issues the buffer-swap pulse to the BRAM manager only at the start of vertical blank, so the display never tears.
- Gates the ray marcher so it cannot start a new frame into a buffer still being displayed.
- Enforces a frame-rate cap in vblanks per frame and reports repeated-frame and frame counts for debug.

---
 rtl/frame_swap_scheduler_pkg.sv | 10 +
 rtl/frame_swap_scheduler_sat_counter.sv | 16 +
 rtl/frame_swap_scheduler.sv | 83 ++++++++
 tb/tb_frame_swap_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_swap_scheduler_pkg.sv
// frame_swap_scheduler_pkg: shared state encoding and vblank counter width
package frame_swap_scheduler_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RENDER  = 2'd1,
    WAIT_VB = 2'd2,
    SWAP    = 2'd3
  } sched_state_t;
  localparam int VB_CNT_W = 8;
endpackage

// File: rtl/frame_swap_scheduler_sat_counter.sv
// frame_swap_scheduler_sat_counter: up-counter that sticks at all-ones, with synchronous clear
module frame_swap_scheduler_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  // clear wins over increment; increment stops once the counter is full
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/frame_swap_scheduler.sv
// frame_swap_scheduler: swaps display buffers only at vblank start and gates the renderer between frames
import frame_swap_scheduler_pkg::*;
module frame_swap_scheduler #(
  parameter int MIN_VBLANKS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             enable_in,
  input  logic             render_done_in,
  input  logic             vsync_start_in,
  output logic             render_go_out,
  output logic             frame_start_out,
  output logic             swap_out,
  output logic             back_buf_out,
  output logic [CNT_W-1:0] frame_count_out,
  output logic [CNT_W-1:0] repeat_count_out,
  output logic [1:0]       state_out
);
  localparam logic [VB_CNT_W:0] MIN_V = (VB_CNT_W+1)'(MIN_VBLANKS);
  sched_state_t        state;
  logic [VB_CNT_W-1:0] vb_cnt;
  logic [VB_CNT_W:0]   vb_next;
  logic                swap_now;
  logic                vs_repeat;
  assign vb_next   = {1'b0, vb_cnt} + {{VB_CNT_W{1'b0}}, 1'b1};
  assign swap_now  = vsync_start_in && state == WAIT_VB && vb_next >= MIN_V;
  assign vs_repeat = vsync_start_in && !swap_now;
  assign state_out = state;
  frame_swap_scheduler_sat_counter #(.W(VB_CNT_W)) u_vb_cnt (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .inc   (vs_repeat),
    .clr   (state == SWAP),
    .q     (vb_cnt)
  );
  frame_swap_scheduler_sat_counter #(.W(CNT_W)) u_repeat_cnt (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .inc   (vs_repeat),
    .clr   (1'b0),
    .q     (repeat_count_out)
  );
  // frame sequencing FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state           <= IDLE;
      render_go_out   <= 1'b0;
      frame_start_out <= 1'b0;
      swap_out        <= 1'b0;
      back_buf_out    <= 1'b0;
      frame_count_out <= '0;
    end else begin
      frame_start_out <= 1'b0;
      swap_out        <= 1'b0;
      case (state)
        IDLE:
          if (enable_in) begin
            state           <= RENDER;
            render_go_out   <= 1'b1;
            frame_start_out <= 1'b1;
          end
        RENDER:
          if (render_done_in) begin
            state         <= WAIT_VB;
            render_go_out <= 1'b0;
          end
        WAIT_VB:
          if (swap_now) begin
            state    <= SWAP;
            swap_out <= 1'b1;
          end
        SWAP: begin
          back_buf_out    <= ~back_buf_out;
          frame_count_out <= frame_count_out + CNT_W'(1);
          state           <= enable_in ? RENDER : IDLE;
          render_go_out   <= enable_in;
          frame_start_out <= enable_in;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_frame_swap_scheduler.sv
// tb_frame_swap_scheduler: directed scenarios checked against a frame-level model and literal expectations
module tb_frame_swap_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, done = 1'b0, vs = 1'b0;
  logic go_a, fs_a, sw_a, bb_a, go_b, fs_b, sw_b, bb_b;
  logic [15:0] fc_a, rc_a, fc_b, rc_b;
  logic [1:0]  st_a, st_b;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    int st;
    bit go, fs, sw, bb;
    int fc, rc, vb;
  } mdl_t;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  frame_swap_scheduler #(.MIN_VBLANKS(1), .CNT_W(16)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .render_done_in(done), .vsync_start_in(vs),
    .render_go_out(go_a), .frame_start_out(fs_a), .swap_out(sw_a), .back_buf_out(bb_a),
    .frame_count_out(fc_a), .repeat_count_out(rc_a), .state_out(st_a)
  );
  frame_swap_scheduler #(.MIN_VBLANKS(3), .CNT_W(16)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .render_done_in(done), .vsync_start_in(vs),
    .render_go_out(go_b), .frame_start_out(fs_b), .swap_out(sw_b), .back_buf_out(bb_b),
    .frame_count_out(fc_b), .repeat_count_out(rc_b), .state_out(st_b)
  );

  function automatic mdl_t zero_m();
    mdl_t m;
    m = '{0, 0, 0, 0, 0, 0, 0, 0};
    return m;
  endfunction

  // one clock of the frame rules: phase 0 idle, 1 rendering, 2 waiting for vblank, 3 swapping
  function automatic mdl_t step(mdl_t m, int mn, bit e, bit d, bit v);
    mdl_t n = m;
    bit swap_now = v && m.st == 2 && (m.vb + 1) >= mn;
    n.fs = 0;
    n.sw = 0;
    if (v && !swap_now) begin
      n.vb = (m.vb == 255) ? 255 : m.vb + 1;
      n.rc = (m.rc == 65535) ? 65535 : m.rc + 1;
    end
    if (m.st == 0 && e) begin n.st = 1; n.fs = 1; end
    else if (m.st == 1 && d) n.st = 2;
    else if (m.st == 2 && swap_now) begin n.st = 3; n.sw = 1; end
    else if (m.st == 3) begin
      n.bb = !m.bb;
      n.fc = (m.fc + 1) % 65536;
      n.vb = 0;
      n.st = e ? 1 : 0;
      n.fs = e;
    end
    n.go = (n.st == 1);
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string t, mdl_t m, logic [1:0] st, logic go, logic fs, logic sw, logic bb,
                     logic [15:0] fc, logic [15:0] rc);
    chk({t, "_state"}, 32'(st), m.st);
    chk({t, "_go"}, 32'(go), 32'(m.go));
    chk({t, "_fstart"}, 32'(fs), 32'(m.fs));
    chk({t, "_swap"}, 32'(sw), 32'(m.sw));
    chk({t, "_backbuf"}, 32'(bb), 32'(m.bb));
    chk({t, "_fcount"}, 32'(fc), m.fc);
    chk({t, "_rcount"}, 32'(rc), m.rc);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ma = zero_m();
      mb = zero_m();
    end else begin
      ma = step(ma, 1, en, done, vs);
      mb = step(mb, 3, en, done, vs);
    end

  always @(negedge clk) begin
    cmp("m1", ma, st_a, go_a, fs_a, sw_a, bb_a, fc_a, rc_a);
    cmp("m3", mb, st_b, go_b, fs_b, sw_b, bb_b, fc_b, rc_b);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(1); done = 1'b0;
  endtask

  task automatic pulse_vs();
    vs = 1'b1; tick(1); vs = 1'b0;
  endtask

  initial begin
    ma = zero_m();
    mb = zero_m();
    tick(3);
    chk("rst_state", 32'(st_a), 0);
    chk("rst_fcount", 32'(fc_a), 0);
    chk("rst_rcount", 32'(rc_a), 0);
    chk("rst_backbuf", 32'(bb_a), 0);
    chk("rst_go", 32'(go_a), 0);
    rst_n = 1'b1;
    tick(1);
    en = 1'b1;
    tick(1);
    chk("start_fstart", 32'(fs_a), 1);
    chk("start_go", 32'(go_a), 1);
    chk("start_state", 32'(st_a), 1);
    tick(1);
    chk("start_fstart_once", 32'(fs_a), 0);
    tick(97);
    pulse_done();
    chk("done_go_low", 32'(go_a), 0);
    chk("done_state", 32'(st_a), 2);
    tick(48);
    pulse_vs();
    chk("vs_swap", 32'(sw_a), 1);
    chk("vs_state", 32'(st_a), 3);
    chk("m3_no_swap", 32'(sw_b), 0);
    tick(1);
    chk("post_backbuf", 32'(bb_a), 1);
    chk("post_fstart", 32'(fs_a), 1);
    chk("post_fcount", 32'(fc_a), 1);
    chk("post_rcount", 32'(rc_a), 0);
    chk("post_swap_off", 32'(sw_a), 0);
    tick(5);
    done = 1'b1; vs = 1'b1;
    tick(1);
    done = 1'b0; vs = 1'b0;
    chk("coinc_no_swap", 32'(sw_a), 0);
    chk("coinc_rcount", 32'(rc_a), 1);
    chk("coinc_state", 32'(st_a), 2);
    tick(3);
    pulse_vs();
    chk("coinc_next_swap", 32'(sw_a), 1);
    tick(1);
    chk("coinc_fcount", 32'(fc_a), 2);
    chk("coinc_backbuf", 32'(bb_a), 0);
    repeat (5) begin
      tick(4);
      pulse_vs();
    end
    chk("slow_state", 32'(st_a), 1);
    chk("slow_rcount", 32'(rc_a), 6);
    tick(2);
    pulse_done();
    tick(2);
    pulse_vs();
    chk("slow_swap", 32'(sw_a), 1);
    chk("slow_rcount_hold", 32'(rc_a), 6);
    tick(1);
    chk("slow_fcount", 32'(fc_a), 3);
    en = 1'b0;
    tick(5);
    chk("noen_go", 32'(go_a), 1);
    pulse_done();
    tick(3);
    pulse_vs();
    chk("noen_swap", 32'(sw_a), 1);
    tick(1);
    chk("noen_state", 32'(st_a), 0);
    chk("noen_go_low", 32'(go_a), 0);
    chk("noen_fstart", 32'(fs_a), 0);
    chk("noen_fcount", 32'(fc_a), 4);
    tick(5);
    chk("noen_idle_go", 32'(go_a), 0);
    en = 1'b1;
    tick(1);
    pulse_done();
    pulse_vs();
    tick(1);
    chk("pre_rst_backbuf", 32'(bb_a), 1);
    chk("pre_rst_fcount", 32'(fc_a), 5);
    pulse_done();
    chk("pre_rst_state", 32'(st_a), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(st_a), 0);
    chk("arst_backbuf", 32'(bb_a), 0);
    chk("arst_fcount", 32'(fc_a), 0);
    chk("arst_rcount", 32'(rc_a), 0);
    chk("arst_go", 32'(go_a), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("m3_start_state", 32'(st_b), 1);
    pulse_done();
    tick(3);
    pulse_vs();
    chk("m3_vs1_state", 32'(st_b), 2);
    chk("m3_vs1_rcount", 32'(rc_b), 1);
    tick(3);
    pulse_vs();
    chk("m3_vs2_swap", 32'(sw_b), 0);
    chk("m3_vs2_rcount", 32'(rc_b), 2);
    tick(3);
    pulse_vs();
    chk("m3_vs3_swap", 32'(sw_b), 1);
    chk("m3_vs3_rcount", 32'(rc_b), 2);
    tick(1);
    chk("m3_fcount", 32'(fc_b), 1);
    chk("m3_backbuf", 32'(bb_b), 1);
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
